ros_meas_sequencer: RTL and testbench
=====================================

ROS_MEAS_SEQUENCER -- requirements
Module: ros_meas_sequencer

Interface
REQ-001 Parameter COUNTER_LENGTH, default 20, width of each oscillator cycle counter.
REQ-002 Parameter GATE_W, default 16, width of gate_len.
REQ-003 Parameter SETTLE_CYC, default 4, idle cycles between counter clear and gate opening.
REQ-004 Parameter SYNC_CYC, default 4, idle cycles between gate closing and latch.
REQ-005 Ports SHALL be, in this order:
- clk  in  1  single clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  begin one sweep; sampled in IDLE only.
- abort  in  1  terminate sweep.
- osc_mask  in  4  bit i enables oscillator i (counter_select value i).
- gate_len  in  GATE_W  gate-open length in clk cycles.
- ser_in  in  1  readout shift-register MSB, before clk XOR.
- gate  out  1  measurement gate.
- ctr_reset  out  1  counter clear.
- latch_counter  out  1  readout load strobe.
- counter_select  out  2  oscillator being read.
- busy  out  1  high in every state except IDLE.
- result_valid  out  1  one-cycle pulse, result fields valid.
- result_sel  out  2  oscillator of current result.
- result_count  out  COUNTER_LENGTH  captured count.
- hdr_err  out  1  header mismatch on current result.
- done  out  1  one-cycle pulse at sweep end.

Function
REQ-006 FSM states SHALL be IDLE, CLR, SETTLE, GATE, SYNC, LATCH, SHIFT, EMIT; all outputs registered.
REQ-007 IDLE + start SHALL load counter_select with lowest set osc_mask bit and enter CLR; osc_mask==0 SHALL instead pulse done next cycle and stay IDLE.
REQ-008 CLR SHALL hold ctr_reset=1 for exactly 2 cycles, then SETTLE for SETTLE_CYC cycles with all strobes low.
REQ-009 GATE SHALL hold gate=1 for exactly max(gate_len,1) cycles; gate_len sampled on CLR entry.
REQ-010 SYNC SHALL hold gate=0 for SYNC_CYC cycles, then LATCH asserts latch_counter for exactly 1 cycle.
REQ-011 SHIFT SHALL last N=COUNTER_LENGTH+4 cycles, sampling ser_in at the end of each, MSB first (first sample = bit N-1).
REQ-012 EMIT SHALL pulse result_valid 1 cycle with result_count = low COUNTER_LENGTH bits, result_sel = counter_select; fields hold until next EMIT.
REQ-013 After EMIT, next higher set osc_mask bit (mask sampled at start) SHALL be selected and CLR entered; if none, done pulses in the same cycle as the return to IDLE.
REQ-014 counter_select SHALL be stable from CLR entry through end of EMIT for each oscillator.
REQ-015 start while busy SHALL be ignored; start and abort together in IDLE: abort wins, stay IDLE.
REQ-016 abort in any non-IDLE state SHALL go to IDLE next cycle, deassert gate/ctr_reset/latch_counter, emit no result, no done.
REQ-017 Counters SHALL be sized to their maximum terminal counts; no wrap-around occurs within a state.

Reset
REQ-018 rst_n low SHALL asynchronously force IDLE and all outputs, result fields and hdr_err to 0; release is synchronous to clk.

Configuration
REQ-019 ROS_SEQ_HDR_CHECK_EN defined: hdr_err = (top 4 captured bits != 4'b1010), valid with result_valid.
REQ-020 ROS_SEQ_HDR_CHECK_EN undefined: hdr_err tied 0, header bits discarded, no comparator logic.

Structure
REQ-021 Shared package ros_pkg SHALL hold the FSM state enum, the 4'b1010 header constant, and oscillator index constants.
REQ-022 One sub-module ros_ser_capture (shift-in register plus bit counter, started by the FSM, done flag back) SHALL implement SHIFT capture.

Verification
REQ-023 osc_mask=4'b0001, gate_len=10, ser_in model returns {1010, 20'h00ABC} -> gate high exactly 10 cycles, one result_valid, result_count=20'h00ABC, result_sel=0, hdr_err=0, done once.
REQ-024 osc_mask=4'b1010 -> results for select 1 then 3 only, ctr_reset pulsed 2 cycles before each gate, done after second result.
REQ-025 gate_len=0 -> gate high exactly 1 cycle; osc_mask=0 with start -> done one cycle later, busy never high.
REQ-026 abort during GATE with gate_len=100 -> gate low next cycle, IDLE, no result_valid, no done; new start then completes normally.
REQ-027 With ROS_SEQ_HDR_CHECK_EN, header 4'b1110 -> hdr_err=1 with result_valid; without macro -> hdr_err=0.
REQ-028 rst_n low mid-SHIFT -> all outputs 0 immediately, no clk edge required.

Source files
------------

// File: rtl/ros_pkg.sv
// Shared types and constants for the ring-oscillator measurement sequencer.
// Holds the FSM state enum, readout header pattern and oscillator indices.
package ros_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    SETTLE,
    GATE,
    SYNC,
    LATCH,
    SHIFT,
    EMIT
  } state_t;

  localparam logic [3:0] HDR_PATTERN = 4'b1010;

  localparam logic [1:0] OSC0 = 2'd0;
  localparam logic [1:0] OSC1 = 2'd1;
  localparam logic [1:0] OSC2 = 2'd2;
  localparam logic [1:0] OSC3 = 2'd3;

  // Lowest set bit of m as {found, index}.
  function automatic logic [2:0] first_osc(
    input logic [3:0] m
  );
    if (m[0])      return {1'b1, OSC0};
    else if (m[1]) return {1'b1, OSC1};
    else if (m[2]) return {1'b1, OSC2};
    else if (m[3]) return {1'b1, OSC3};
    else           return 3'b000;
  endfunction

endpackage

// File: rtl/ros_ser_capture.sv
// Serial readout capture: shifts ser_in MSB-first for NBITS cycles while en.
// Ports: clk, rst_n, start (clear), en (shift), ser_in, last, word.
module ros_ser_capture #(
  parameter int NBITS  = 24,
  parameter int DATA_W = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              en,
  input  logic              ser_in,
  output logic              last,
  output logic [DATA_W-1:0] word
);

  localparam int CW = $clog2(NBITS);

  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] sh;

  // Value including the bit sampled on this edge, so the
  // FSM can register the full word as it leaves SHIFT.
  assign word = {sh[DATA_W-2:0], ser_in};
  assign last = en && (cnt == CW'(NBITS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      sh  <= '0;
    end else if (start) begin
      cnt <= '0;
      sh  <= '0;
    end else if (en) begin
      cnt <= cnt + CW'(1);
      sh  <= word;
    end
  end

endmodule

// File: rtl/ros_meas_sequencer.sv
// Sweeps enabled ring oscillators: clear, settle, gate, sync, latch, read.
// Optional header check under macro ROS_SEQ_HDR_CHECK_EN.
// Ports: clk, rst_n, start, abort, osc_mask, gate_len, ser_in -> gate,
// ctr_reset, latch_counter, counter_select, busy, result_*, hdr_err, done.
module ros_meas_sequencer
  import ros_pkg::*;
#(
  parameter int COUNTER_LENGTH = 20,
  parameter int GATE_W         = 16,
  parameter int SETTLE_CYC     = 4,
  parameter int SYNC_CYC       = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      abort,
  input  logic [3:0]                osc_mask,
  input  logic [GATE_W-1:0]         gate_len,
  input  logic                      ser_in,
  output logic                      gate,
  output logic                      ctr_reset,
  output logic                      latch_counter,
  output logic [1:0]                counter_select,
  output logic                      busy,
  output logic                      result_valid,
  output logic [1:0]                result_sel,
  output logic [COUNTER_LENGTH-1:0] result_count,
  output logic                      hdr_err,
  output logic                      done
);

  localparam int N = COUNTER_LENGTH + 4;
`ifdef ROS_SEQ_HDR_CHECK_EN
  localparam int CAP_W = N;
`else
  localparam int CAP_W = COUNTER_LENGTH;
`endif

  localparam int SW  = $clog2(SETTLE_CYC + 1);
  localparam int YW  = $clog2(SYNC_CYC + 1);
  localparam int CW0 = (GATE_W > 2) ? GATE_W : 2;
  localparam int CW1 = (CW0 > SW) ? CW0 : SW;
  localparam int CW  = (CW1 > YW) ? CW1 : YW;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [GATE_W-1:0] glen;
  logic [3:0]        mask_q;

  logic              cap_start;
  logic              cap_en;
  logic              cap_last;
  logic [CAP_W-1:0]  cap_word;

  logic [GATE_W-1:0] glen_in;
  logic [2:0]        first_pick;
  logic [2:0]        next_pick;
  logic [3:0]        hi_mask;

  assign cap_start = (state == LATCH);
  assign cap_en    = (state == SHIFT);

  always_comb begin
    glen_in    = (gate_len == '0) ? GATE_W'(1) : gate_len;
    first_pick = first_osc(osc_mask);
    // Bits strictly above the current oscillator.
    hi_mask    = mask_q & ~((4'd2 << counter_select) - 4'd1);
    next_pick  = first_osc(hi_mask);
  end

  ros_ser_capture #(
    .NBITS  (N),
    .DATA_W (CAP_W)
  ) u_cap (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (cap_start),
    .en     (cap_en),
    .ser_in (ser_in),
    .last   (cap_last),
    .word   (cap_word)
  );

`ifdef ROS_SEQ_HDR_CHECK_EN
  logic hdr_q;
  assign hdr_err = hdr_q;
`else
  assign hdr_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      cnt            <= '0;
      glen           <= '0;
      mask_q         <= '0;
      gate           <= 1'b0;
      ctr_reset      <= 1'b0;
      latch_counter  <= 1'b0;
      counter_select <= '0;
      busy           <= 1'b0;
      result_valid   <= 1'b0;
      result_sel     <= '0;
      result_count   <= '0;
      done           <= 1'b0;
`ifdef ROS_SEQ_HDR_CHECK_EN
      hdr_q          <= 1'b0;
`endif
    end else begin
      done         <= 1'b0;
      result_valid <= 1'b0;
      if (abort && state != IDLE) begin
        state         <= IDLE;
        busy          <= 1'b0;
        gate          <= 1'b0;
        ctr_reset     <= 1'b0;
        latch_counter <= 1'b0;
        cnt           <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (start && !abort) begin
              if (first_pick[2]) begin
                state          <= CLR;
                busy           <= 1'b1;
                ctr_reset      <= 1'b1;
                cnt            <= '0;
                counter_select <= first_pick[1:0];
                mask_q         <= osc_mask;
                glen           <= glen_in;
              end else begin
                done <= 1'b1;
              end
            end
          end
          CLR: begin
            if (cnt == CW'(1)) begin
              state     <= SETTLE;
              ctr_reset <= 1'b0;
              cnt       <= '0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          SETTLE: begin
            if (cnt == CW'(SETTLE_CYC - 1)) begin
              state <= GATE;
              gate  <= 1'b1;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          GATE: begin
            if (cnt == CW'(glen - GATE_W'(1))) begin
              state <= SYNC;
              gate  <= 1'b0;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          SYNC: begin
            if (cnt == CW'(SYNC_CYC - 1)) begin
              state         <= LATCH;
              latch_counter <= 1'b1;
              cnt           <= '0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          LATCH: begin
            state         <= SHIFT;
            latch_counter <= 1'b0;
          end
          SHIFT: begin
            if (cap_last) begin
              state        <= EMIT;
              result_valid <= 1'b1;
              result_sel   <= counter_select;
              result_count <= cap_word[COUNTER_LENGTH-1:0];
`ifdef ROS_SEQ_HDR_CHECK_EN
              hdr_q <= (cap_word[N-1 -: 4] != HDR_PATTERN);
`endif
            end
          end
          EMIT: begin
            if (next_pick[2]) begin
              state          <= CLR;
              ctr_reset      <= 1'b1;
              cnt            <= '0;
              counter_select <= next_pick[1:0];
              glen           <= glen_in;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ros_meas_sequencer.sv
// Directed table-driven bench for ros_meas_sequencer.
// Models the oscillator readout shift register feeding ser_in.
module tb_ros_meas_sequencer;

`ifdef ROS_SEQ_HDR_CHECK_EN
  localparam bit HDR_EN = 1'b1;
`else
  localparam bit HDR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [3:0]  osc_mask;
  logic [15:0] gate_len;
  logic        ser_in;
  logic        gate;
  logic        ctr_reset;
  logic        latch_counter;
  logic [1:0]  counter_select;
  logic        busy;
  logic        result_valid;
  logic [1:0]  result_sel;
  logic [19:0] result_count;
  logic        hdr_err;
  logic        done;

  always #5 clk = ~clk;

  ros_meas_sequencer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .abort          (abort),
    .osc_mask       (osc_mask),
    .gate_len       (gate_len),
    .ser_in         (ser_in),
    .gate           (gate),
    .ctr_reset      (ctr_reset),
    .latch_counter  (latch_counter),
    .counter_select (counter_select),
    .busy           (busy),
    .result_valid   (result_valid),
    .result_sel     (result_sel),
    .result_count   (result_count),
    .hdr_err        (hdr_err),
    .done           (done)
  );

  // Readout register: loads on the latch strobe, then
  // presents its MSB and shifts left every clock.
  logic [23:0] word;
  logic [23:0] sr = '0;
  assign ser_in = sr[23];
  always @(posedge clk) begin
    if (latch_counter) sr <= word;
    else               sr <= {sr[22:0], 1'b0};
  end

  int errors = 0;
  int checks = 0;

  // Monitor, sampled on the falling edge.
  int          nres, ndone, gate_cyc, clr_cyc;
  int          cur_run, max_run, min_run;
  int          done_busy;
  bit          busy_seen;
  logic [1:0]  m_sel [4];
  logic [19:0] m_cnt [4];
  logic        m_hdr [4];

  always @(negedge clk) begin
    if (gate) begin
      gate_cyc++;
      cur_run++;
    end else if (cur_run > 0) begin
      if (cur_run > max_run) max_run = cur_run;
      if (cur_run < min_run) min_run = cur_run;
      cur_run = 0;
    end
    if (ctr_reset) clr_cyc++;
    if (busy) busy_seen = 1'b1;
    if (result_valid) begin
      if (nres < 4) begin
        m_sel[nres] = result_sel;
        m_cnt[nres] = result_count;
        m_hdr[nres] = hdr_err;
      end
      nres++;
    end
    if (done) begin
      ndone++;
      if (busy) done_busy++;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic mon_clear();
    nres      = 0;
    ndone     = 0;
    gate_cyc  = 0;
    clr_cyc   = 0;
    cur_run   = 0;
    max_run   = 0;
    min_run   = 1 << 30;
    done_busy = 0;
    busy_seen = 1'b0;
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (ndone == 0 && k < 3000) begin
      tick();
      k++;
    end
    checks++;
    if (ndone == 0) begin
      errors++;
      $display("FAIL timeout: got no done expected done");
    end
    tick();
    tick();
  endtask

  typedef struct {
    logic [3:0]  mask;
    logic [15:0] glen;
    logic [23:0] w;
    int          nres;
    logic [7:0]  sels;
    int          run;
    logic [19:0] cnt;
    logic        bad_hdr;
  } vec_t;

  vec_t vecs [6];

  task automatic run_vec(input int v);
    vec_t t;
    t        = vecs[v];
    osc_mask = t.mask;
    gate_len = t.glen;
    word     = t.w;
    mon_clear();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (20) tick();
    // Must be ignored: sweep still running.
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done();
    chk($sformatf("v%0d nres", v), nres, t.nres);
    chk($sformatf("v%0d ndone", v), ndone, 1);
    chk($sformatf("v%0d done_busy", v), done_busy, 0);
    chk($sformatf("v%0d max_run", v), max_run, t.run);
    chk($sformatf("v%0d min_run", v), min_run, t.run);
    chk($sformatf("v%0d gate_cyc", v),
        gate_cyc, t.run * t.nres);
    chk($sformatf("v%0d clr_cyc", v),
        clr_cyc, 2 * t.nres);
    for (int i = 0; i < t.nres && i < 4; i++) begin
      chk($sformatf("v%0d sel%0d", v, i),
          m_sel[i], t.sels[2*i +: 2]);
      chk($sformatf("v%0d cnt%0d", v, i),
          m_cnt[i], t.cnt);
      chk($sformatf("v%0d hdr%0d", v, i),
          m_hdr[i], t.bad_hdr & HDR_EN);
    end
  endtask

  initial begin
    vecs[0] = '{4'b0001, 16'd10, 24'hA00ABC, 1,
                8'h00, 10, 20'h00ABC, 1'b0};
    vecs[1] = '{4'b1010, 16'd5, 24'hA12345, 2,
                8'h0D, 5, 20'h12345, 1'b0};
    vecs[2] = '{4'b0100, 16'd0, 24'hAFFFFF, 1,
                8'h02, 1, 20'hFFFFF, 1'b0};
    vecs[3] = '{4'b1111, 16'd3, 24'hA00001, 4,
                8'hE4, 3, 20'h00001, 1'b0};
    vecs[4] = '{4'b1000, 16'd2, 24'hE5A5A5, 1,
                8'h03, 2, 20'h5A5A5, 1'b1};
    vecs[5] = '{4'b0110, 16'd1, 24'h5ABCDE, 2,
                8'h09, 1, 20'hABCDE, 1'b1};

    rst_n    = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    osc_mask = '0;
    gate_len = '0;
    word     = '0;
    mon_clear();
    repeat (3) tick();
    chk("reset outs",
        {gate, ctr_reset, latch_counter, counter_select,
         busy, result_valid, result_sel, result_count,
         hdr_err, done}, 32'd0);
    rst_n = 1'b1;
    tick();

    for (int v = 0; v < 6; v++) run_vec(v);

    // Empty mask: done the next cycle, never busy.
    mon_clear();
    osc_mask = 4'b0000;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("mask0 done", done, 1'b1);
    chk("mask0 busy", busy, 1'b0);
    tick();
    chk("mask0 done pulse", done, 1'b0);
    repeat (3) tick();
    chk("mask0 busy_seen", busy_seen, 1'b0);
    chk("mask0 ndone", ndone, 1);

    // start with abort in IDLE: abort wins.
    mon_clear();
    osc_mask = 4'b0001;
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    repeat (5) tick();
    chk("st+ab busy_seen", busy_seen, 1'b0);
    chk("st+ab ndone", ndone, 0);

    // Abort in the middle of a long gate.
    mon_clear();
    osc_mask = 4'b0001;
    gate_len = 16'd100;
    word     = 24'hA00ABC;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 50 && !gate; k++) tick();
    chk("abort gate open", gate, 1'b1);
    repeat (5) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort gate", gate, 1'b0);
    chk("abort busy", busy, 1'b0);
    repeat (200) tick();
    chk("abort nres", nres, 0);
    chk("abort ndone", ndone, 0);

    run_vec(0);

    // Asynchronous reset mid-SHIFT.
    osc_mask = 4'b1000;
    gate_len = 16'd2;
    word     = 24'hA12345;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 50 && !latch_counter; k++)
      tick();
    chk("rst latch seen", latch_counter, 1'b1);
    repeat (5) tick();
    chk("rst busy before", busy, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst mid-shift",
        {gate, ctr_reset, latch_counter, counter_select,
         busy, result_valid, result_sel, result_count,
         hdr_err, done}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
